// File: rtl/md5_msg_padder_pkg.sv
// Shared constants and types for the MD5 message padder: block geometry,
// padding marker, FSM state encodings and the 512-bit block type.
package md5_msg_padder_pkg;
  localparam int MD5_BLOCK_BYTES = 64;
  localparam int MD5_LEN_OFFSET  = 56;
  localparam logic [7:0] MD5_PAD_BYTE = 8'h80;

  localparam logic [2:0] ST_FILL      = 3'd0;
  localparam logic [2:0] ST_PAD       = 3'd1;
  localparam logic [2:0] ST_LEN       = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_SEND_LAST = 3'd4;

  // byte k lives at [8k+7:8k]
  typedef logic [MD5_BLOCK_BYTES-1:0][7:0] md5_block_t;
endpackage

// File: rtl/md5_msg_padder_if.sv
// Byte-stream input and padded-block output handshakes of the MD5 padder.
interface md5_msg_padder_if;
  import md5_msg_padder_pkg::*;

  logic [7:0] in_byte;
  logic       in_keep;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  md5_block_t block_out;
  logic       block_valid;
  logic       block_ready;
  logic       block_last;
  logic       busy;

  modport master (
    output in_byte, in_keep, in_valid, in_last, block_ready,
    input  in_ready, block_out, block_valid, block_last, busy
  );

  modport slave (
    input  in_byte, in_keep, in_valid, in_last, block_ready,
    output in_ready, block_out, block_valid, block_last, busy
  );
endinterface

// File: rtl/md5_msg_padder.sv
// Packs a byte stream into RFC 1321 padded 512-bit blocks (0x80 marker,
// zero fill, 64-bit little-endian bit length) behind a valid/ready handshake.
module md5_msg_padder
  import md5_msg_padder_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input logic             clk,
  input logic             reset,
  md5_msg_padder_if.slave bus
);

  logic [2:0]       state, state_nxt;
  md5_block_t       blk;
  logic [6:0]       pos;
  logic [6:0]       pos_inc;
  logic [LEN_W-1:0] cnt;
  logic [63:0]      bit_len;
  logic             ended;   // message ended exactly on a block boundary
  logic             marked;  // 0x80 already placed for this message
  logic             beat, hs;

  assign beat      = bus.in_valid && bus.in_ready;
  assign hs        = bus.block_valid && bus.block_ready;
  assign pos_inc   = pos + 7'd1;
  assign bit_len   = 64'(cnt) << 3;
  assign bus.block_out = blk;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL:
        if (beat) begin
          if (bus.in_keep && pos_inc == 7'(MD5_BLOCK_BYTES)) state_nxt = ST_SEND;
          else if (bus.in_last)                              state_nxt = ST_PAD;
        end
      ST_PAD:  state_nxt = (pos_inc <= 7'(MD5_LEN_OFFSET)) ? ST_LEN : ST_SEND;
      ST_LEN:  state_nxt = ST_SEND_LAST;
      ST_SEND:
        if (hs) begin
          if (marked)     state_nxt = ST_LEN;
          else if (ended) state_nxt = ST_PAD;
          else            state_nxt = ST_FILL;
        end
      ST_SEND_LAST: if (hs) state_nxt = ST_FILL;
      default:      state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_FILL;
      blk             <= '0;
      pos             <= '0;
      cnt             <= '0;
      ended           <= 1'b0;
      marked          <= 1'b0;
      bus.in_ready    <= 1'b0;
      bus.block_valid <= 1'b0;
      bus.block_last  <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus.in_ready <= (state_nxt == ST_FILL);
      // outputs are registered one cycle behind entry into a send state
      bus.block_valid <= ((state == ST_SEND) || (state == ST_SEND_LAST)) && !hs;
      bus.block_last  <= (state == ST_SEND_LAST) && !hs;

      case (state)
        ST_FILL:
          if (beat && (bus.in_keep || bus.in_last)) begin
            bus.busy <= 1'b1;
            ended    <= bus.in_last;
            if (bus.in_keep) begin
              blk[pos[5:0]] <= bus.in_byte;
              pos           <= pos_inc;
              cnt           <= cnt + LEN_W'(1);
            end
          end
        ST_PAD: begin
          blk[pos[5:0]] <= MD5_PAD_BYTE;
          pos           <= pos_inc;
          marked        <= 1'b1;
        end
        ST_LEN:
          for (int k = 0; k < 8; k++) blk[MD5_LEN_OFFSET + k] <= bit_len[8*k +: 8];
        ST_SEND:
          if (hs) begin
            blk <= '0;
            pos <= '0;
          end
        ST_SEND_LAST:
          if (hs) begin
            blk      <= '0;
            pos      <= '0;
            cnt      <= '0;
            ended    <= 1'b0;
            marked   <= 1'b0;
            bus.busy <= 1'b0;
          end
        default: ;
      endcase
    end
  end

endmodule
